// File: rtl/elevator_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : elevator_request_scheduler
// Purpose  : Latches hall up/down calls and car calls per floor, clears
//            serviced requests while the car disembarks, and runs a SCAN
//            style direction FSM (IDLE/UP/DOWN) that finishes a sweep before
//            reversing.
// Ports    : clk, reset (sync, active-high)
//            hall_up_req/hall_dn_req/car_req  - level request buttons
//            current_floor, current_up_ndown  - car position / direction
//            deassert_floor                   - car disembarking at floor
//            queue_status, queue_empty        - pending request view
//            next_up_ndown                    - registered next direction
//            hall_up_lamp, hall_dn_lamp       - pending hall call masks
//            service_count (optional)         - saturating service counter
// Options  : define SCHED_SERVICE_COUNT_EN to add the service_count output.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_request_scheduler #(
  parameter int NUM_FLOORS     = 7,
  parameter int FLOOR_W        = 3,
  parameter int DEFAULT_DIR_UP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] hall_up_req,
  input  logic [NUM_FLOORS-1:0] hall_dn_req,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  current_up_ndown,
  input  logic                  deassert_floor,
  output logic [NUM_FLOORS-1:0] queue_status,
  output logic                  queue_empty,
  output logic                  next_up_ndown,
  output logic [NUM_FLOORS-1:0] hall_up_lamp,
`ifdef SCHED_SERVICE_COUNT_EN
  output logic [NUM_FLOORS-1:0] hall_dn_lamp,
  output logic [7:0]            service_count
`else
  output logic [NUM_FLOORS-1:0] hall_dn_lamp
`endif
);

  // Top floor has no up button, ground floor has no down button.
  localparam logic [NUM_FLOORS-1:0] UP_VALID = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_VALID = {{(NUM_FLOORS-1){1'b1}}, 1'b0};
  localparam logic [FLOOR_W-1:0]    TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic                  DEF_UP    = (DEFAULT_DIR_UP != 0);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;

  logic [NUM_FLOORS-1:0] up_pend, dn_pend, car_pend;
  logic [1:0]            state;

  logic                  floor_valid;
  logic [NUM_FLOORS-1:0] floor_onehot;
  logic                  above, below;
  logic [NUM_FLOORS-1:0] clr_up, clr_dn, clr_car;
  logic [1:0]            state_nxt;
  logic                  dir_nxt;

  assign queue_status = up_pend | dn_pend | car_pend;
  assign queue_empty  = ~|queue_status;
  assign hall_up_lamp = up_pend;
  assign hall_dn_lamp = dn_pend;

  // An out-of-range floor index (e.g. 7) selects nothing: no masks, no clear.
  assign floor_valid  = (current_floor < FLOOR_W'(NUM_FLOORS));
  assign floor_onehot = floor_valid ? (NUM_FLOORS'(1) << current_floor) : '0;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (floor_valid && queue_status[i]) begin
        if (FLOOR_W'(i) > current_floor) above = 1'b1;
        if (FLOOR_W'(i) < current_floor) below = 1'b1;
      end
    end
  end

  // The hall call opposite to travel is only answered here when the sweep
  // has nothing left further on; otherwise the car will return for it.
  always_comb begin
    clr_up  = '0;
    clr_dn  = '0;
    clr_car = '0;
    if (deassert_floor) begin
      clr_car = floor_onehot;
      if (current_up_ndown) begin
        clr_up = floor_onehot;
        if (!above) clr_dn = floor_onehot;
      end else begin
        clr_dn = floor_onehot;
        if (!below) clr_up = floor_onehot;
      end
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_UP: begin
        if (above)      state_nxt = ST_UP;
        else if (below) state_nxt = ST_DOWN;
      end
      ST_DOWN: begin
        if (below)      state_nxt = ST_DOWN;
        else if (above) state_nxt = ST_UP;
      end
      default: begin
        if (above && below) state_nxt = DEF_UP ? ST_UP : ST_DOWN;
        else if (above)     state_nxt = ST_UP;
        else if (below)     state_nxt = ST_DOWN;
      end
    endcase
  end

  always_comb begin
    dir_nxt = DEF_UP;
    case (state_nxt)
      ST_UP:   dir_nxt = 1'b1;
      ST_DOWN: dir_nxt = 1'b0;
      default: begin
        if (current_floor == TOP_FLOOR)    dir_nxt = 1'b0;
        else if (current_floor == '0)      dir_nxt = 1'b1;
        else                               dir_nxt = DEF_UP;
      end
    endcase
  end

  // Clear wins over a simultaneous set; a held button re-latches next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      up_pend       <= '0;
      dn_pend       <= '0;
      car_pend      <= '0;
      state         <= ST_IDLE;
      next_up_ndown <= DEF_UP;
    end else begin
      up_pend       <= (up_pend  | (hall_up_req & UP_VALID)) & ~clr_up;
      dn_pend       <= (dn_pend  | (hall_dn_req & DN_VALID)) & ~clr_dn;
      car_pend      <= (car_pend | car_req)                  & ~clr_car;
      state         <= state_nxt;
      next_up_ndown <= dir_nxt;
    end
  end

`ifdef SCHED_SERVICE_COUNT_EN
  logic deassert_q;
  logic serviced;

  // Counts disembark events, not cycles: only the rising edge of
  // deassert_floor that actually retires a pending request.
  assign serviced = deassert_floor && !deassert_q &&
                    (|((clr_up & up_pend) | (clr_dn & dn_pend) | (clr_car & car_pend)));

  always_ff @(posedge clk) begin
    if (reset) begin
      deassert_q    <= 1'b0;
      service_count <= '0;
    end else begin
      deassert_q <= deassert_floor;
      if (serviced && service_count != 8'hFF)
        service_count <= service_count + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_elevator_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_request_scheduler
// Purpose  : Directed self-checking bench for elevator_request_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_elevator_request_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] hall_up_req, hall_dn_req, car_req;
  logic [2:0] current_floor;
  logic       current_up_ndown;
  logic       deassert_floor;
  logic [6:0] queue_status;
  logic       queue_empty;
  logic       next_up_ndown;
  logic [6:0] hall_up_lamp, hall_dn_lamp;
`ifdef SCHED_SERVICE_COUNT_EN
  logic [7:0] service_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elevator_request_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .hall_up_req      (hall_up_req),
    .hall_dn_req      (hall_dn_req),
    .car_req          (car_req),
    .current_floor    (current_floor),
    .current_up_ndown (current_up_ndown),
    .deassert_floor   (deassert_floor),
    .queue_status     (queue_status),
    .queue_empty      (queue_empty),
    .next_up_ndown    (next_up_ndown),
    .hall_up_lamp     (hall_up_lamp),
`ifdef SCHED_SERVICE_COUNT_EN
    .hall_dn_lamp     (hall_dn_lamp),
    .service_count    (service_count)
`else
    .hall_dn_lamp     (hall_dn_lamp)
`endif
  );

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; hall_up_req = '0; hall_dn_req = '0; car_req = '0;
    current_floor = 3'd2; current_up_ndown = 1'b1; deassert_floor = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(10);
    checks++;
    if (queue_status !== 7'b0 || queue_empty !== 1'b1 || next_up_ndown !== 1'b1 ||
        hall_up_lamp !== 7'b0 || hall_dn_lamp !== 7'b0) begin
      failures++;
      $display("FAIL reset_state: q=%b e=%b dir=%b ul=%b dl=%b required q=0000000 e=1 dir=1 lamps=0",
               queue_status, queue_empty, next_up_ndown, hall_up_lamp, hall_dn_lamp);
    end
  endtask

  task automatic test_ignored_bits;
    hall_up_req = 7'b1000000; hall_dn_req = 7'b0000001;
    tick();
    hall_up_req = '0; hall_dn_req = '0;
    checks++;
    if (queue_status !== 7'b0 || hall_up_lamp !== 7'b0 || hall_dn_lamp !== 7'b0) begin
      failures++;
      $display("FAIL ignored_bits: q=%b ul=%b dl=%b required all zero",
               queue_status, hall_up_lamp, hall_dn_lamp);
    end
  endtask

  task automatic test_sweep;
    current_floor = 3'd2; car_req = 7'b0100000;
    tick();
    car_req = '0;
    checks++;
    if (queue_status !== 7'b0100000 || queue_empty !== 1'b0) begin
      failures++;
      $display("FAIL car_latch: q=%b e=%b required q=0100000 e=0", queue_status, queue_empty);
    end
    tick();
    checks++;
    if (next_up_ndown !== 1'b1) begin
      failures++;
      $display("FAIL sweep_up: dir=%b required 1", next_up_ndown);
    end
    current_floor = 3'd3; hall_dn_req = 7'b0000010;
    tick();
    hall_dn_req = '0;
    tick();
    checks++;
    if (queue_status !== 7'b0100010 || next_up_ndown !== 1'b1 || hall_dn_lamp !== 7'b0000010) begin
      failures++;
      $display("FAIL up_held: q=%b dir=%b dl=%b required q=0100010 dir=1 dl=0000010",
               queue_status, next_up_ndown, hall_dn_lamp);
    end
    current_floor = 3'd5; deassert_floor = 1'b1;
    tick();
    deassert_floor = 1'b0;
    checks++;
    if (queue_status !== 7'b0000010 || next_up_ndown !== 1'b0) begin
      failures++;
      $display("FAIL reverse_down: q=%b dir=%b required q=0000010 dir=0", queue_status, next_up_ndown);
    end
    current_floor = 3'd1; current_up_ndown = 1'b0; deassert_floor = 1'b1;
    tick();
    deassert_floor = 1'b0;
    checks++;
    if (queue_empty !== 1'b1 || next_up_ndown !== 1'b1) begin
      failures++;
      $display("FAIL sweep_done: e=%b dir=%b required e=1 dir=1", queue_empty, next_up_ndown);
    end
  endtask

  task automatic test_same_floor_hall;
    current_floor = 3'd4; current_up_ndown = 1'b1;
    hall_up_req = 7'b0010000; hall_dn_req = 7'b0010000; car_req = 7'b1000000;
    tick();
    hall_up_req = '0; hall_dn_req = '0; car_req = '0;
    checks++;
    if (queue_status !== 7'b1010000 || hall_up_lamp !== 7'b0010000 || hall_dn_lamp !== 7'b0010000) begin
      failures++;
      $display("FAIL hall_latch: q=%b ul=%b dl=%b required q=1010000 ul=0010000 dl=0010000",
               queue_status, hall_up_lamp, hall_dn_lamp);
    end
    deassert_floor = 1'b1;
    tick();
    deassert_floor = 1'b0;
    checks++;
    if (hall_up_lamp !== 7'b0 || hall_dn_lamp !== 7'b0010000 || next_up_ndown !== 1'b1) begin
      failures++;
      $display("FAIL same_floor_up_only: ul=%b dl=%b dir=%b required ul=0 dl=0010000 dir=1",
               hall_up_lamp, hall_dn_lamp, next_up_ndown);
    end
    current_floor = 3'd6; deassert_floor = 1'b1;
    tick();
    deassert_floor = 1'b0;
    checks++;
    if (queue_status !== 7'b0010000 || next_up_ndown !== 1'b0) begin
      failures++;
      $display("FAIL top_clear: q=%b dir=%b required q=0010000 dir=0", queue_status, next_up_ndown);
    end
    current_floor = 3'd4; deassert_floor = 1'b1;
    tick();
    deassert_floor = 1'b0;
    checks++;
    if (queue_empty !== 1'b1 || next_up_ndown !== 1'b1) begin
      failures++;
      $display("FAIL dn_cleared_nothing_above: e=%b dir=%b required e=1 dir=1", queue_empty, next_up_ndown);
    end
  endtask

  task automatic test_down_clear;
    current_floor = 3'd3; current_up_ndown = 1'b0;
    hall_up_req = 7'b0001000; hall_dn_req = 7'b0001000; car_req = 7'b0000001;
    tick();
    hall_up_req = '0; hall_dn_req = '0; car_req = '0;
    deassert_floor = 1'b1;
    tick();
    deassert_floor = 1'b0;
    checks++;
    if (hall_up_lamp !== 7'b0001000 || hall_dn_lamp !== 7'b0 || next_up_ndown !== 1'b0) begin
      failures++;
      $display("FAIL down_clear_dn_only: ul=%b dl=%b dir=%b required ul=0001000 dl=0 dir=0",
               hall_up_lamp, hall_dn_lamp, next_up_ndown);
    end
    current_floor = 3'd0; deassert_floor = 1'b1;
    tick();
    current_floor = 3'd3;
    tick();
    deassert_floor = 1'b0;
    checks++;
    if (queue_empty !== 1'b1) begin
      failures++;
      $display("FAIL up_cleared_nothing_below: q=%b required 0000000", queue_status);
    end
  endtask

  task automatic test_edge_floors;
    current_floor = 3'd6;
    tick();
    checks++;
    if (next_up_ndown !== 1'b0) begin
      failures++;
      $display("FAIL idle_top_dir: dir=%b required 0", next_up_ndown);
    end
    current_floor = 3'd0;
    tick();
    checks++;
    if (next_up_ndown !== 1'b1) begin
      failures++;
      $display("FAIL idle_bottom_dir: dir=%b required 1", next_up_ndown);
    end
    current_floor = 3'd7; car_req = 7'b0001000;
    tick();
    car_req = '0; deassert_floor = 1'b1;
    tick(2);
    deassert_floor = 1'b0;
    checks++;
    if (queue_status !== 7'b0001000 || next_up_ndown !== 1'b1) begin
      failures++;
      $display("FAIL floor7_no_clear: q=%b dir=%b required q=0001000 dir=1", queue_status, next_up_ndown);
    end
    current_floor = 3'd3; deassert_floor = 1'b1;
    tick();
    deassert_floor = 1'b0;
  endtask

  task automatic test_collision;
    current_floor = 3'd2; car_req = 7'b0000100; deassert_floor = 1'b1;
    tick();
    checks++;
    if (queue_status !== 7'b0) begin
      failures++;
      $display("FAIL clear_wins_1: q=%b required 0000000", queue_status);
    end
    tick();
    checks++;
    if (queue_status !== 7'b0) begin
      failures++;
      $display("FAIL clear_wins_2: q=%b required 0000000", queue_status);
    end
    deassert_floor = 1'b0;
    tick();
    car_req = '0;
    checks++;
    if (queue_status !== 7'b0000100) begin
      failures++;
      $display("FAIL relatch: q=%b required 0000100", queue_status);
    end
  endtask

  task automatic test_reset_mid_sweep;
    car_req = 7'b1000000; hall_up_req = 7'b0000010;
    tick();
    car_req = '0; hall_up_req = '0;
    current_floor = 3'd6;
    tick();
    checks++;
    if (next_up_ndown !== 1'b0 || queue_status !== 7'b1000110) begin
      failures++;
      $display("FAIL pre_reset: q=%b dir=%b required q=1000110 dir=0", queue_status, next_up_ndown);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (queue_status !== 7'b0 || queue_empty !== 1'b1 || next_up_ndown !== 1'b1 ||
        hall_up_lamp !== 7'b0 || hall_dn_lamp !== 7'b0) begin
      failures++;
      $display("FAIL mid_reset: q=%b e=%b dir=%b ul=%b dl=%b required q=0 e=1 dir=1 lamps=0",
               queue_status, queue_empty, next_up_ndown, hall_up_lamp, hall_dn_lamp);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (queue_empty !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_discard: q=%b required 0000000", queue_status);
    end
  endtask

`ifdef SCHED_SERVICE_COUNT_EN
  task automatic test_service_count;
    current_floor = 3'd3; current_up_ndown = 1'b1;
    car_req = 7'b0001000;
    tick();
    deassert_floor = 1'b1;
    tick(4);
    deassert_floor = 1'b0;
    car_req = '0;
    tick();
    checks++;
    if (service_count !== 8'd1) begin
      failures++;
      $display("FAIL count_held_once: count=%0d required 1", service_count);
    end
    for (int i = 0; i < 299; i++) begin
      car_req = 7'b0001000;
      tick();
      car_req = '0; deassert_floor = 1'b1;
      tick();
      deassert_floor = 1'b0;
      tick();
    end
    checks++;
    if (service_count !== 8'd255) begin
      failures++;
      $display("FAIL count_saturate: count=%0d required 255", service_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ignored_bits();
    test_sweep();
    test_same_floor_hall();
    test_down_clear();
    test_edge_floors();
    test_collision();
    test_reset_mid_sweep();
`ifdef SCHED_SERVICE_COUNT_EN
    test_service_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
